// File: rtl/nand_bus_sequencer_pkg.sv
// Shared types for the NAND bus sequencer.
// FSM states, write/read sub-phases, latched op fields, opcodes.
package nand_bus_sequencer_pkg;

  localparam int TW = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD1,
    S_ADDR,
    S_WDATA,
    S_CMD2,
    S_WAIT_WB,
    S_WAIT_RB,
    S_RDATA,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_START,
    PH_LOW,
    PH_HIGH
  } phase_e;

  typedef struct packed {
    logic [7:0] cmd1;
    logic [7:0] cmd2;
    logic       has_cmd2;
    logic [2:0] naddr;
    logic       dir;
    logic [7:0] len;
  } op_t;

  localparam logic [7:0] OP_READ1  = 8'h00;
  localparam logic [7:0] OP_READ2  = 8'h30;
  localparam logic [7:0] OP_PROG1  = 8'h80;
  localparam logic [7:0] OP_PROG2  = 8'h10;
  localparam logic [7:0] OP_STATUS = 8'h70;
  localparam logic [7:0] OP_RESET  = 8'hFF;
  localparam logic [7:0] OP_ERASE1 = 8'h60;
  localparam logic [7:0] OP_ERASE2 = 8'hD0;

  function automatic state_e after_addr(op_t op);
    if (!op.dir && op.len != 8'd0) return S_WDATA;
    if (op.has_cmd2) return S_CMD2;
    if (op.dir && op.len != 8'd0) return S_WAIT_WB;
    return S_DONE;
  endfunction

endpackage

// File: rtl/nand_cycle_timer.sv
// Loadable down-counter for flash pin timing.
// 'expired' is high once the count has reached zero.
module nand_cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  // load wins, otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) cnt_d = val;
    else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/nand_bus_sequencer.sv
// Raw NAND bus sequencer: one operation per request,
// CMD1 / addr / wdata / CMD2 / busy wait / rdata.
module nand_bus_sequencer
  import nand_bus_sequencer_pkg::*;
#(
  parameter int T_WP       = 2,
  parameter int T_WH       = 2,
  parameter int T_RP       = 2,
  parameter int T_REH      = 2,
  parameter int T_WB       = 4,
  parameter int RB_TIMEOUT = 65535
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [7:0] op_cmd1,
  input  logic [7:0] op_cmd2,
  input  logic       op_has_cmd2,
  input  logic [2:0] op_naddr,
  input  logic       op_dir,
  input  logic [7:0] op_len,
  input  logic [7:0] tx_dout,
  input  logic       tx_empty,
  output logic       tx_rd_en,
  output logic [7:0] rx_din,
  output logic       rx_wr_en,
  input  logic       rx_full,
  output logic       F_nCE,
  output logic       F_CLE,
  output logic       F_ALE,
  output logic       F_nWE,
  output logic       F_nRE,
  output logic       F_nWP,
  input  logic       F_nRB,
  output logic [7:0] F_DIO_o,
  output logic       F_DIO_oe,
  input  logic [7:0] F_DIO_i,
  output logic       op_done,
  output logic       op_err
);

  localparam logic [TW-1:0] LD_WP  = TW'(T_WP - 1);
  localparam logic [TW-1:0] LD_WH  = TW'(T_WH - 1);
  localparam logic [TW-1:0] LD_RP  = TW'(T_RP - 1);
  localparam logic [TW-1:0] LD_REH = TW'(T_REH - 1);
  localparam logic [TW-1:0] LD_WB  = TW'(T_WB - 1);
  localparam logic [TW-1:0] LD_RB  = TW'(RB_TIMEOUT - 1);

  state_e state_q, state_d;
  phase_e ph_q, ph_d;
  op_t    op_q, op_d;

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] rd_q, rd_d;
  logic       err_q, err_d;
  logic       rxw_q, rxw_d;
  logic       nwp_q, nwp_d;
  logic       rb_s1_q, rb_s1_d;
  logic       rb_s2_q, rb_s2_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_exp;

  logic       tx_src;
  logic [7:0] wr_byte;
  state_e     wr_next;
  logic       wr_st;

  nand_cycle_timer #(.W(TW)) u_tmr (
    .clk     (PCLK),
    .rst_n   (PRESETN),
    .load    (tmr_load),
    .val     (tmr_val),
    .expired (tmr_exp)
  );

  // byte source and follow-on state of the current write state
  always_comb begin
    tx_src  = 1'b0;
    wr_byte = 8'h00;
    wr_next = S_DONE;
    unique case (state_q)
      S_CMD1: begin
        wr_byte = op_q.cmd1;
        wr_next = (op_q.naddr != 3'd0) ? S_ADDR : after_addr(op_q);
      end
      S_ADDR: begin
        tx_src  = 1'b1;
        wr_byte = tx_dout;
        wr_next = after_addr(op_q);
      end
      S_WDATA: begin
        tx_src  = 1'b1;
        wr_byte = tx_dout;
        wr_next = op_q.has_cmd2 ? S_CMD2 : S_DONE;
      end
      S_CMD2: begin
        wr_byte = op_q.cmd2;
        wr_next = S_WAIT_WB;
      end
      default: ;
    endcase
  end

  // next state, cycle sub-phase, counters and timer loads
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    rd_d     = rd_q;
    err_d    = err_q;
    rxw_d    = 1'b0;
    nwp_d    = 1'b1;
    rb_s1_d  = F_nRB;
    rb_s2_d  = rb_s1_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          op_d.cmd1     = op_cmd1;
          op_d.cmd2     = op_cmd2;
          op_d.has_cmd2 = op_has_cmd2;
          op_d.naddr    = (op_naddr > 3'd5) ? 3'd5 : op_naddr;
          op_d.dir      = op_dir;
          op_d.len      = op_len;
          err_d         = 1'b0;
          state_d       = S_CMD1;
        end
      end
      S_CMD1, S_ADDR, S_WDATA, S_CMD2: begin
        unique case (ph_q)
          PH_START: begin
            if (!tx_src || !tx_empty) begin
              ph_d     = PH_LOW;
              dout_d   = wr_byte;
              tmr_load = 1'b1;
              tmr_val  = LD_WP;
            end
          end
          PH_LOW: begin
            if (tmr_exp) begin
              ph_d     = PH_HIGH;
              tmr_load = 1'b1;
              tmr_val  = LD_WH;
            end
          end
          default: begin
            if (tmr_exp) begin
              ph_d = PH_START;
              if (!tx_src || cnt_q == 8'd1) state_d = wr_next;
              else cnt_d = cnt_q - 8'd1;
            end
          end
        endcase
      end
      S_WAIT_WB: begin
        if (tmr_exp) state_d = op_q.has_cmd2 ? S_WAIT_RB : S_RDATA;
      end
      S_WAIT_RB: begin
        if (rb_s2_q) begin
          state_d = (op_q.dir && op_q.len != 8'd0) ? S_RDATA : S_DONE;
        end else if (tmr_exp) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_RDATA: begin
        unique case (ph_q)
          PH_START: begin
            if (!rx_full) begin
              ph_d     = PH_LOW;
              tmr_load = 1'b1;
              tmr_val  = LD_RP;
            end
          end
          PH_LOW: begin
            if (tmr_exp) begin
              ph_d     = PH_HIGH;
              rd_d     = F_DIO_i;
              rxw_d    = 1'b1;
              tmr_load = 1'b1;
              tmr_val  = LD_REH;
            end
          end
          default: begin
            if (tmr_exp) begin
              ph_d = PH_START;
              if (cnt_q == 8'd1) state_d = S_DONE;
              else cnt_d = cnt_q - 8'd1;
            end
          end
        endcase
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      ph_d = PH_START;
      unique case (state_d)
        S_ADDR:    cnt_d = {5'd0, op_q.naddr};
        S_WDATA:   cnt_d = op_q.len;
        S_RDATA:   cnt_d = op_q.len;
        S_WAIT_WB: begin
          tmr_load = 1'b1;
          tmr_val  = LD_WB;
        end
        S_WAIT_RB: begin
          tmr_load = 1'b1;
          tmr_val  = LD_RB;
        end
        default: ;
      endcase
    end
  end

  // pin and handshake decode from registered state
  always_comb begin
    wr_st = (state_q == S_CMD1) || (state_q == S_ADDR) ||
            (state_q == S_WDATA) || (state_q == S_CMD2);
    op_ready = (state_q == S_IDLE);
    F_nCE    = (state_q == S_IDLE) || (state_q == S_DONE);
    F_CLE    = (state_q == S_CMD1) || (state_q == S_CMD2);
    F_ALE    = (state_q == S_ADDR);
    F_nWE    = !(wr_st && ph_q == PH_LOW);
    F_nRE    = !(state_q == S_RDATA && ph_q == PH_LOW);
    F_nWP    = nwp_q;
    F_DIO_oe = wr_st;
    F_DIO_o  = wr_st ? dout_q : 8'h00;
    tx_rd_en = tx_src && ph_q == PH_LOW && tmr_exp;
    rx_wr_en = rxw_q;
    rx_din   = rd_q;
    op_done  = (state_q == S_DONE);
    op_err   = (state_q == S_DONE) && err_q;
  end

  // state and datapath registers
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q <= S_IDLE;
      ph_q    <= PH_START;
      op_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      rxw_q   <= 1'b0;
      nwp_q   <= 1'b0;
      rb_s1_q <= 1'b1;
      rb_s2_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      rxw_q   <= rxw_d;
      nwp_q   <= nwp_d;
      rb_s1_q <= rb_s1_d;
      rb_s2_q <= rb_s2_d;
    end
  end

endmodule
